// File: rtl/move_tiros_param.sv
// Shot mover: walks every shot slot once per start, moves loaded shots along their direction
// and retires (or, with `TIRO_WRAP_EN`, wraps) shots that leave the X_MAX/Y_MAX field.
module move_tiros_param #(
  parameter int N_TIROS = 8,
  parameter int COORD_W = 4,
  parameter int X_MAX   = 11,
  parameter int Y_MAX   = 11,
  parameter int STEP    = 1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         start,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(N_TIROS)-1:0]   mem_addr,
  input  logic                         mem_rd_loaded,
  input  logic [2:0]                   mem_rd_dir,
  input  logic [COORD_W-1:0]           mem_rd_x,
  input  logic [COORD_W-1:0]           mem_rd_y,
  output logic                         mem_we,
  output logic                         mem_wr_loaded,
  output logic [COORD_W-1:0]           mem_wr_x,
  output logic [COORD_W-1:0]           mem_wr_y,
  output logic [$clog2(N_TIROS):0]     removed_count,
  output logic [3:0]                   db_estado
);

  localparam int AW = $clog2(N_TIROS);
  localparam logic [COORD_W:0] STEP_C = (COORD_W+1)'(STEP);
  localparam logic [COORD_W:0] XMAX_C = (COORD_W+1)'(X_MAX);
  localparam logic [COORD_W:0] YMAX_C = (COORD_W+1)'(Y_MAX);
  localparam logic [AW-1:0]    LAST_C = AW'(N_TIROS - 1);
  localparam logic [AW:0]      NT_C   = (AW+1)'(N_TIROS);

  typedef enum logic [3:0] {
    IDLE  = 4'd0,
    READ  = 4'd1,
    EVAL  = 4'd2,
    WRITE = 4'd3,
    NEXT  = 4'd4,
    DONE  = 4'd5
  } state_t;

  // Axis motion: 2'b01 increment, 2'b10 decrement, otherwise the axis stays put.
  function automatic logic [1:0] x_move(input logic [2:0] dir);
    case (dir)
      3'd0, 3'd4, 3'd5: x_move = 2'b01;
      3'd1, 3'd6, 3'd7: x_move = 2'b10;
      default:          x_move = 2'b00;
    endcase
  endfunction

  function automatic logic [1:0] y_move(input logic [2:0] dir);
    case (dir)
      3'd2, 3'd4, 3'd6: y_move = 2'b01;
      3'd3, 3'd5, 3'd7: y_move = 2'b10;
      default:          y_move = 2'b00;
    endcase
  endfunction

  // Returns {exit, coord}; on exit coord already holds the wrapped-around position.
  function automatic logic [COORD_W:0] axis_step(input logic [COORD_W-1:0] c,
                                                 input logic [1:0] mv,
                                                 input logic [COORD_W:0] maxv);
    logic [COORD_W:0] ext;
    logic [COORD_W:0] r;
    logic             ex;
    ext = {1'b0, c};
    r   = ext;
    ex  = 1'b0;
    if (mv == 2'b01) begin
      r = ext + STEP_C;
      if (r > maxv) begin
        ex = 1'b1;
        r  = r - (maxv + 1'b1);
      end
    end else if (mv == 2'b10) begin
      if (ext < STEP_C) begin
        ex = 1'b1;
        r  = ext + (maxv + 1'b1) - STEP_C;
      end else begin
        r = ext - STEP_C;
      end
    end
    axis_step = {ex, r[COORD_W-1:0]};
  endfunction

  function automatic logic [AW:0] sat_inc(input logic [AW:0] cnt);
    sat_inc = (cnt >= NT_C) ? NT_C : cnt + 1'b1;
  endfunction

  state_t state, state_nx;
  logic [COORD_W:0] x_res, y_res;
  logic             exit_any;

  assign x_res    = axis_step(mem_rd_x, x_move(mem_rd_dir), XMAX_C);
  assign y_res    = axis_step(mem_rd_y, y_move(mem_rd_dir), YMAX_C);
  assign exit_any = x_res[COORD_W] | y_res[COORD_W];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = READ;
      READ:    state_nx = EVAL;
      EVAL:    state_nx = mem_rd_loaded ? WRITE : NEXT;
      WRITE:   state_nx = NEXT;
      NEXT:    state_nx = (mem_addr == LAST_C) ? DONE : READ;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs decoded from state so reset drops the write strobe in the same cycle.
  assign busy      = (state != IDLE);
  assign done      = (state == DONE);
  assign mem_we    = (state == WRITE);
  assign db_estado = state;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_addr      <= '0;
      mem_wr_loaded <= 1'b0;
      mem_wr_x      <= '0;
      mem_wr_y      <= '0;
      removed_count <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          mem_addr      <= '0;
          removed_count <= '0;
        end
        EVAL: if (mem_rd_loaded) begin
`ifdef TIRO_WRAP_EN
          mem_wr_loaded <= 1'b1;
          mem_wr_x      <= x_res[COORD_W-1:0];
          mem_wr_y      <= y_res[COORD_W-1:0];
`else
          if (exit_any) begin
            mem_wr_loaded <= 1'b0;
            mem_wr_x      <= mem_rd_x;
            mem_wr_y      <= mem_rd_y;
            removed_count <= sat_inc(removed_count);
          end else begin
            mem_wr_loaded <= 1'b1;
            mem_wr_x      <= x_res[COORD_W-1:0];
            mem_wr_y      <= y_res[COORD_W-1:0];
          end
`endif
        end
        NEXT: if (mem_addr != LAST_C) mem_addr <= mem_addr + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_move_tiros_param.sv
// Scoreboard bench for move_tiros_param: expected slot writes are queued per pass and
// checked by a monitor whenever the DUT strobes mem_we.
module tb_move_tiros_param;

  logic       clock = 1'b0;
  logic       reset;
  logic       start;
  logic       busy, done;
  logic [2:0] mem_addr;
  logic       mem_rd_loaded;
  logic [2:0] mem_rd_dir;
  logic [3:0] mem_rd_x, mem_rd_y;
  logic       mem_we, mem_wr_loaded;
  logic [3:0] mem_wr_x, mem_wr_y;
  logic [3:0] removed_count;
  logic [3:0] db_estado;

  move_tiros_param dut (
    .clock(clock), .reset(reset), .start(start), .busy(busy), .done(done),
    .mem_addr(mem_addr), .mem_rd_loaded(mem_rd_loaded), .mem_rd_dir(mem_rd_dir),
    .mem_rd_x(mem_rd_x), .mem_rd_y(mem_rd_y), .mem_we(mem_we),
    .mem_wr_loaded(mem_wr_loaded), .mem_wr_x(mem_wr_x), .mem_wr_y(mem_wr_y),
    .removed_count(removed_count), .db_estado(db_estado)
  );

  always #5 clock = ~clock;

  logic       m_ld [8];
  logic [2:0] m_dir[8];
  logic [3:0] m_x  [8];
  logic [3:0] m_y  [8];

  // Synchronous-read shot memory: data appears one cycle after the address.
  always @(posedge clock) begin
    mem_rd_loaded <= m_ld[mem_addr];
    mem_rd_dir    <= m_dir[mem_addr];
    mem_rd_x      <= m_x[mem_addr];
    mem_rd_y      <= m_y[mem_addr];
    if (mem_we) begin
      m_ld[mem_addr] <= mem_wr_loaded;
      m_x[mem_addr]  <= mem_wr_x;
      m_y[mem_addr]  <= mem_wr_y;
    end
  end

  typedef struct packed {
    logic [2:0] addr;
    logic       ld;
    logic [3:0] x;
    logic [3:0] y;
  } wr_t;

  wr_t exp_q[$];
  int  checks = 0;
  int  errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clock) begin
    if (mem_we) begin
      check("we_in_write", int'(db_estado), 3);
      if (exp_q.size() == 0) begin
        check("unexpected_write_addr", int'(mem_addr), 8);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        check("wr_slot", int'({mem_addr, mem_wr_loaded, mem_wr_x, mem_wr_y}), int'(e));
      end
    end
  end

  task automatic clear_mem();
    for (int i = 0; i < 8; i++) begin
      m_ld[i] = 1'b0; m_dir[i] = 3'd0; m_x[i] = 4'd0; m_y[i] = 4'd0;
    end
  endtask

  task automatic load_slot(input int i, input logic [2:0] d, input logic [3:0] x, input logic [3:0] y);
    m_ld[i] = 1'b1; m_dir[i] = d; m_x[i] = x; m_y[i] = y;
  endtask

  task automatic expect_wr(input int a, input logic ld, input logic [3:0] x, input logic [3:0] y);
    wr_t e;
    e.addr = 3'(a); e.ld = ld; e.x = x; e.y = y;
    exp_q.push_back(e);
  endtask

  task automatic run_pass(input int exp_cycles, input int exp_removed, input bit poke_start);
    int cyc;
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    cyc = 1;
    check("first_state", int'(db_estado), 1);
    check("first_addr", int'(mem_addr), 0);
    check("busy_in_pass", int'(busy), 1);
    while (!done && cyc < 200) begin
      @(negedge clock);
      cyc++;
      start = (poke_start && cyc == 10) ? 1'b1 : 1'b0;
    end
    start = 1'b0;
    check("done_cycle", cyc, exp_cycles);
    check("removed_at_done", int'(removed_count), exp_removed);
    @(negedge clock);
    check("idle_busy", int'(busy), 0);
    check("done_pulse_len", int'(done), 0);
    check("removed_hold", int'(removed_count), exp_removed);
    check("pending_writes", exp_q.size(), 0);
    exp_q.delete();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t limit 500000", $time);
    $fatal(1);
  end

  initial begin
    int found;
    reset = 1'b1;
    start = 1'b0;
    clear_mem();
    repeat (3) @(negedge clock);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_we", int'(mem_we), 0);
    check("rst_addr", int'(mem_addr), 0);
    check("rst_wr", int'({mem_wr_loaded, mem_wr_x, mem_wr_y}), 0);
    check("rst_removed", int'(removed_count), 0);
    check("rst_state", int'(db_estado), 0);
    reset = 1'b0;
    repeat (2) @(negedge clock);

    // All slots empty
    run_pass(25, 0, 1'b0);

    // Single +X move, with a start pulse mid-pass that must be ignored
    clear_mem();
    load_slot(2, 3'd0, 4'd5, 4'd3);
    expect_wr(2, 1'b1, 4'd6, 4'd3);
    run_pass(26, 0, 1'b1);

    // -X-Y from the left edge
    clear_mem();
    load_slot(0, 3'd7, 4'd0, 4'd4);
`ifdef TIRO_WRAP_EN
    expect_wr(0, 1'b1, 4'd11, 4'd3);
    run_pass(26, 0, 1'b0);
`else
    expect_wr(0, 1'b0, 4'd0, 4'd4);
    run_pass(26, 1, 1'b0);
`endif

    // +X+Y from the top-right corner
    clear_mem();
    load_slot(5, 3'd4, 4'd11, 4'd11);
`ifdef TIRO_WRAP_EN
    expect_wr(5, 1'b1, 4'd0, 4'd0);
    run_pass(26, 0, 1'b0);
`else
    expect_wr(5, 1'b0, 4'd11, 4'd11);
    run_pass(26, 1, 1'b0);
`endif

    // Mixed: diagonal exiting on Y only plus three in-field moves
    clear_mem();
    load_slot(0, 3'd5, 4'd3, 4'd0);
    load_slot(1, 3'd1, 4'd7, 4'd2);
    load_slot(2, 3'd6, 4'd4, 4'd9);
    load_slot(3, 3'd3, 4'd2, 4'd1);
`ifdef TIRO_WRAP_EN
    expect_wr(0, 1'b1, 4'd4, 4'd11);
`else
    expect_wr(0, 1'b0, 4'd3, 4'd0);
`endif
    expect_wr(1, 1'b1, 4'd6, 4'd2);
    expect_wr(2, 1'b1, 4'd3, 4'd10);
    expect_wr(3, 1'b1, 4'd2, 4'd0);
`ifdef TIRO_WRAP_EN
    run_pass(29, 0, 1'b0);
`else
    run_pass(29, 1, 1'b0);
`endif

    // Every slot loaded at an edge, each direction once
    clear_mem();
    load_slot(0, 3'd0, 4'd11, 4'd5);
    load_slot(1, 3'd1, 4'd0,  4'd5);
    load_slot(2, 3'd2, 4'd5,  4'd11);
    load_slot(3, 3'd3, 4'd5,  4'd0);
    load_slot(4, 3'd4, 4'd11, 4'd11);
    load_slot(5, 3'd5, 4'd11, 4'd0);
    load_slot(6, 3'd6, 4'd0,  4'd11);
    load_slot(7, 3'd7, 4'd0,  4'd0);
`ifdef TIRO_WRAP_EN
    expect_wr(0, 1'b1, 4'd0,  4'd5);
    expect_wr(1, 1'b1, 4'd11, 4'd5);
    expect_wr(2, 1'b1, 4'd5,  4'd0);
    expect_wr(3, 1'b1, 4'd5,  4'd11);
    expect_wr(4, 1'b1, 4'd0,  4'd0);
    expect_wr(5, 1'b1, 4'd0,  4'd11);
    expect_wr(6, 1'b1, 4'd11, 4'd0);
    expect_wr(7, 1'b1, 4'd11, 4'd11);
    run_pass(33, 0, 1'b0);
`else
    expect_wr(0, 1'b0, 4'd11, 4'd5);
    expect_wr(1, 1'b0, 4'd0,  4'd5);
    expect_wr(2, 1'b0, 4'd5,  4'd11);
    expect_wr(3, 1'b0, 4'd5,  4'd0);
    expect_wr(4, 1'b0, 4'd11, 4'd11);
    expect_wr(5, 1'b0, 4'd11, 4'd0);
    expect_wr(6, 1'b0, 4'd0,  4'd11);
    expect_wr(7, 1'b0, 4'd0,  4'd0);
    run_pass(33, 8, 1'b0);
`endif

    // Reset asserted while slot 3 is being written
    clear_mem();
    for (int i = 0; i < 8; i++) load_slot(i, 3'd0, 4'd1, 4'd1);
    for (int i = 0; i < 4; i++) expect_wr(i, 1'b1, 4'd2, 4'd1);
    @(negedge clock) start = 1'b1;
    @(negedge clock) start = 1'b0;
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clock);
      if (mem_we && mem_addr == 3'd3) found = 1;
    end
    check("reach_write3", found, 1);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_we", int'(mem_we), 0);
    check("rst_mid_busy", int'(busy), 0);
    check("rst_mid_state", int'(db_estado), 0);
    check("rst_mid_addr", int'(mem_addr), 0);
    check("rst_mid_pending", exp_q.size(), 0);
    exp_q.delete();
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < 8; i++)
      check("slot_after_rst", int'(m_x[i]), (i < 3) ? 2 : 1);

    // First pass after reset starts from slot 0
    for (int i = 0; i < 8; i++) expect_wr(i, 1'b1, (i < 3) ? 4'd3 : 4'd2, 4'd1);
    run_pass(33, 0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
